// File: rtl/width_128to24_unpack.sv
// Unpacks 128-bit push-only input words into a 24-bit valid/ready stream, MSB first.
// Bits live in an MSB-aligned residual buffer; input words are placed right below the current fill level.
module width_128to24_unpack #(
  parameter int BUF_W = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  input  logic [127:0] data_in,
  input  logic         flush,
  input  logic         ready_in,
  output logic         valid_out,
  output logic [23:0]  data_out,
  output logic         overflow,
  output logic [8:0]   level
);

  localparam int IN_W  = 128;
  localparam int OUT_W = 24;
  localparam int CW    = 9;

  logic [BUF_W-1:0] bits_reg;
  logic [BUF_W-1:0] bits_next;
  logic [BUF_W-1:0] bits_popped;
  logic [BUF_W-1:0] placed;
  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    cnt_popped;
  logic             overflow_reg;
  logic             overflow_next;
  logic             pop;
  logic             fits;

  assign valid_out = (cnt_reg >= CW'(OUT_W));
  assign data_out  = bits_reg[BUF_W-1 -: OUT_W];
  assign level     = cnt_reg;
  assign overflow  = overflow_reg;

  assign pop = valid_out && ready_in;

  always_comb begin
    bits_popped   = bits_reg;
    cnt_popped    = cnt_reg;
    placed        = '0;
    fits          = 1'b0;
    bits_next     = bits_reg;
    cnt_next      = cnt_reg;
    overflow_next = overflow_reg;

    // The pop is applied first so that a same-cycle push sees the freed room.
    if (pop) begin
      bits_popped = bits_reg << OUT_W;
      cnt_popped  = cnt_reg - CW'(OUT_W);
    end

    // Shifting the word down from the top by the fill level is the same as
    // shifting it up by BUF_W-128-c1, without a negative-shift corner.
    placed = {data_in, {(BUF_W-IN_W){1'b0}}} >> cnt_popped;
    fits   = ({{(32-CW){1'b0}}, cnt_popped} + 32'(IN_W)) <= 32'(BUF_W);

    bits_next = bits_popped;
    cnt_next  = cnt_popped;

    if (flush) begin
      bits_next     = '0;
      cnt_next      = '0;
      overflow_next = 1'b0;
    end else if (valid_in) begin
      if (fits) begin
        bits_next = bits_popped | placed;
        cnt_next  = cnt_popped + CW'(IN_W);
      end else begin
        overflow_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_reg     <= '0;
      cnt_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      bits_reg     <= bits_next;
      cnt_reg      <= cnt_next;
      overflow_reg <= overflow_next;
    end
  end

endmodule

// File: tb/tb_width_128to24_unpack.sv
// Randomized and directed checks of width_128to24_unpack against a bit-queue reference model.
module tb_width_128to24_unpack;

  logic         clk;
  logic         rst_n;
  logic         valid_in;
  logic [127:0] data_in;
  logic         flush;
  logic         ready_in;
  logic         valid_out;
  logic [23:0]  data_out;
  logic         overflow;
  logic [8:0]   level;

  int n_vec;
  int n_bad;

  // Reference model: the buffered stream as a queue of bits, oldest first.
  bit mq[$];
  bit movf;

  width_128to24_unpack #(.BUF_W(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .flush     (flush),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .overflow  (overflow),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] m_data();
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 24; i++)
      if (i < mq.size()) r[23-i] = mq[i];
    return r;
  endfunction

  function automatic logic m_valid();
    return mq.size() >= 24;
  endfunction

  function automatic logic [8:0] m_level();
    return 9'(mq.size());
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_step(input logic vi, input logic [127:0] d, input logic fl, input logic rdy);
    if (fl) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      if (rdy && mq.size() >= 24)
        for (int i = 0; i < 24; i++) void'(mq.pop_front());
      if (vi) begin
        if (mq.size() + 128 <= 256)
          for (int i = 127; i >= 0; i--) mq.push_back(d[i]);
        else
          movf = 1'b1;
      end
    end
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, settle.
  task automatic cyc(input logic vi, input logic [127:0] d, input logic fl, input logic rdy);
    valid_in = vi;
    data_in  = d;
    flush    = fl;
    ready_in = rdy;
    @(posedge clk);
    model_step(vi, d, fl, rdy);
    #1;
    valid_in = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_in = 1'b1; data_in = '1; flush = 1'b0; ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    n_vec++; if (data_out !== 24'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 000000", data_out); end
    n_vec++; if (level !== 9'd0) begin n_bad++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_vec++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    valid_in = 1'b0;
    rst_n = 1'b1;
    mq.delete(); movf = 1'b0;
    cyc(0, '0, 0, 0);
    n_vec++; if (level !== 9'd0) begin n_bad++; $display("FAIL reset_idle_level: got %0d expected 0", level); end
    $display("test_reset done");
  endtask

  task automatic test_straddle();
    logic [23:0] exp_a [5];
    exp_a = '{24'h000102, 24'h030405, 24'h060708, 24'h090A0B, 24'h0C0D0E};
    cyc(1, 128'h000102030405060708090A0B0C0D0E0F, 0, 1);
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (valid_out !== 1'b1 || data_out !== exp_a[k]) begin
        n_bad++; $display("FAIL straddle_A%0d: got v=%b d=%h expected v=1 d=%h", k, valid_out, data_out, exp_a[k]);
      end
      cyc(0, '0, 0, 1);
    end
    n_vec++;
    if (valid_out !== 1'b0 || level !== 9'd8) begin
      n_bad++; $display("FAIL straddle_residue: got v=%b level=%0d expected v=0 level=8", valid_out, level);
    end
    cyc(1, 128'h101112131415161718191A1B1C1D1E1F, 0, 1);
    n_vec++;
    if (data_out !== 24'h0F1011 || valid_out !== 1'b1) begin
      n_bad++; $display("FAIL straddle_B_first: got v=%b d=%h expected v=1 d=0f1011", valid_out, data_out);
    end
    cyc(0, '0, 0, 1);
    n_vec++;
    if (level !== 9'd112 || data_out !== m_data()) begin
      n_bad++; $display("FAIL straddle_B_level: got level=%0d d=%h expected level=112 d=%h", level, data_out, m_data());
    end
    $display("test_straddle done");
  endtask

  task automatic test_three_words();
    logic [383:0] cat;
    logic [23:0]  got [$];
    logic [23:0]  exp_w;
    logic [127:0] w [3];
    for (int i = 0; i < 3; i++) w[i] = rnd128();
    cat = {w[0], w[1], w[2]};
    cyc(0, '0, 1, 0);
    for (int t = 0; t < 30; t++) begin
      if (valid_out) got.push_back(data_out);
      cyc((t == 0 || t == 6 || t == 12), w[t/6 < 3 ? t/6 : 0], 0, 1);
    end
    n_vec++;
    if (got.size() != 16) begin
      n_bad++; $display("FAIL three_words_count: got %0d words expected 16", got.size());
    end
    for (int k = 0; k < 16 && k < got.size(); k++) begin
      exp_w = cat[383-24*k -: 24];
      n_vec++;
      if (got[k] !== exp_w) begin
        n_bad++; $display("FAIL three_words_w%0d: got %h expected %h", k, got[k], exp_w);
      end
    end
    n_vec++;
    if (level !== 9'd0 || overflow !== 1'b0) begin
      n_bad++; $display("FAIL three_words_end: got level=%0d ovf=%b expected level=0 ovf=0", level, overflow);
    end
    $display("test_three_words done: %0d words", got.size());
  endtask

  task automatic test_backpressure();
    int outs;
    logic [8:0] exp_lv [3];
    exp_lv = '{9'd128, 9'd256, 9'd256};
    cyc(0, '0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, rnd128(), 0, 0);
      n_vec++;
      if (level !== exp_lv[i] || valid_out !== 1'b1) begin
        n_bad++; $display("FAIL backpressure_fill%0d: got level=%0d v=%b expected level=%0d v=1", i, level, valid_out, exp_lv[i]);
      end
    end
    n_vec++;
    if (overflow !== 1'b1) begin n_bad++; $display("FAIL backpressure_ovf: got %b expected 1", overflow); end
    outs = 0;
    for (int t = 0; t < 14; t++) begin
      if (valid_out) begin
        outs++;
        n_vec++;
        if (data_out !== m_data()) begin
          n_bad++; $display("FAIL backpressure_word%0d: got %h expected %h", outs, data_out, m_data());
        end
      end
      cyc(0, '0, 0, 1);
    end
    n_vec++;
    if (outs != 10 || level !== 9'd16 || valid_out !== 1'b0) begin
      n_bad++; $display("FAIL backpressure_drain: got outs=%0d level=%0d v=%b expected outs=10 level=16 v=0", outs, level, valid_out);
    end
    $display("test_backpressure done: %0d words", outs);
  endtask

  task automatic test_pop_push();
    cyc(0, '0, 1, 0);
    cyc(1, rnd128(), 0, 0);
    cyc(1, rnd128(), 0, 0);
    cyc(1, rnd128(), 0, 1);
    n_vec++;
    if (level !== 9'd232 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL pop_push_full: got level=%0d ovf=%b expected level=232 ovf=1", level, overflow);
    end
    cyc(0, '0, 1, 0);
    cyc(1, rnd128(), 0, 0);
    cyc(1, rnd128(), 0, 0);
    repeat (10) cyc(0, '0, 0, 1);
    cyc(1, rnd128(), 0, 0);
    n_vec++;
    if (level !== 9'd144) begin n_bad++; $display("FAIL pop_push_144: got %0d expected 144", level); end
    cyc(1, rnd128(), 0, 1);
    n_vec++;
    if (level !== 9'd248 || overflow !== 1'b0 || data_out !== m_data()) begin
      n_bad++; $display("FAIL pop_push_accept: got level=%0d ovf=%b d=%h expected level=248 ovf=0 d=%h", level, overflow, data_out, m_data());
    end
    $display("test_pop_push done");
  endtask

  task automatic test_flush_reset();
    cyc(0, '0, 1, 0);
    cyc(1, rnd128(), 0, 0);
    cyc(1, rnd128(), 0, 0);
    cyc(1, rnd128(), 0, 0);
    repeat (9) cyc(0, '0, 0, 1);
    n_vec++;
    if (level !== 9'd40 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL flush_pre: got level=%0d ovf=%b expected level=40 ovf=1", level, overflow);
    end
    cyc(1, rnd128(), 1, 1);
    n_vec++;
    if (level !== 9'd0 || overflow !== 1'b0 || valid_out !== 1'b0) begin
      n_bad++; $display("FAIL flush_with_push: got level=%0d ovf=%b v=%b expected 0 0 0", level, overflow, valid_out);
    end
    cyc(1, rnd128(), 0, 1);
    cyc(1, rnd128(), 0, 1);
    cyc(0, '0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete(); movf = 1'b0;
    n_vec++;
    if (level !== 9'd0 || overflow !== 1'b0 || valid_out !== 1'b0 || data_out !== 24'h0) begin
      n_bad++; $display("FAIL async_reset_now: got level=%0d ovf=%b v=%b d=%h expected all 0", level, overflow, valid_out, data_out);
    end
    valid_in = 1'b1; data_in = rnd128(); ready_in = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (level !== 9'd0 || overflow !== 1'b0 || valid_out !== 1'b0) begin
      n_bad++; $display("FAIL async_reset_edge: got level=%0d ovf=%b v=%b expected 0 0 0", level, overflow, valid_out);
    end
    valid_in = 1'b0;
    rst_n = 1'b1;
    cyc(0, '0, 0, 0);
    $display("test_flush_reset done");
  endtask

  task automatic test_random();
    logic vi, fl, rdy;
    for (int t = 0; t < 400; t++) begin
      vi  = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 49) == 0);
      cyc(vi, rnd128(), fl, rdy);
      n_vec++;
      if (valid_out !== m_valid() || data_out !== m_data() || level !== m_level() || overflow !== movf) begin
        n_bad++;
        $display("FAIL random_t%0d: got v=%b d=%h lv=%0d ovf=%b expected v=%b d=%h lv=%0d ovf=%b",
                 t, valid_out, data_out, level, overflow, m_valid(), m_data(), m_level(), movf);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    movf  = 1'b0;
    rst_n = 1'b0;
    valid_in = 1'b0; data_in = '0; flush = 1'b0; ready_in = 1'b0;
    test_reset();
    test_straddle();
    test_three_words();
    test_backpressure();
    test_pop_push();
    test_flush_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
